operand_loader: RTL and testbench

- Front end that drives the operand/opcode load interface of the 4-bit ALU from the board's raw push-buttons and 4-bit slide switches.
- Synchronises and debounces three buttons and turns each press into one clean single-cycle load strobe.
- Presents a registered copy of the switch value on the data bus for that strobe.
- Enforces the entry order A -> B -> opcode, and exposes stage, ready and error status for the board LEDs.

---
 rtl/operand_loader.sv | 160 ++++++++++++++++
 tb/tb_operand_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : operand_loader
//  Description : Push-button / slide-switch front end for the 4-bit ALU.
//                Synchronises and debounces three buttons, turns each press
//                into a single load strobe with a registered copy of the
//                switches, and enforces the entry order A -> B -> opcode.
//  Revision    : 1.0  initial release
// ============================================================================
module operand_loader #(
    parameter int DEB_CYCLES = 500000,
    parameter int DEB_W      = 20
) (
    input  logic       clk,
    input  logic       clr_common,
    input  logic [3:0] sw,
    input  logic       btn_A,
    input  logic       btn_B,
    input  logic       btn_op,
    output logic [3:0] data,
    output logic       ld_A,
    output logic       ld_B,
    output logic       ld_op,
    output logic [1:0] stage,
    output logic       ready,
    output logic       err
);

    // Debounce counter value on the last differing cycle before the flip
    localparam logic [DEB_W-1:0] c_DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT_A  = 2'd0,
        S_WAIT_B  = 2'd1,
        S_WAIT_OP = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Button vector ordering: bit 0 = A, bit 1 = B, bit 2 = opcode
    logic [2:0] w_btn_raw;
    logic [2:0] r_btn_m;
    logic [2:0] r_btn_s;
    logic [3:0] r_sw_m;
    logic [3:0] r_sw_s;
    logic [2:0] w_press;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_ld;
    logic [2:0] w_ld_nxt;
    logic [3:0] r_data;
    logic [3:0] w_data_nxt;
    logic       r_err;
    logic       w_err_nxt;
    logic       r_ready;
    logic [2:0] w_exp_mask;

    assign w_btn_raw = {btn_op, btn_B, btn_A};

    // Two-flop synchronisers for the buttons and the switch bits
    always_ff @(posedge clk) begin
        if (clr_common) begin
            r_btn_m <= '0;
            r_btn_s <= '0;
            r_sw_m  <= '0;
            r_sw_s  <= '0;
        end else begin
            r_btn_m <= w_btn_raw;
            r_btn_s <= r_btn_m;
            r_sw_m  <= sw;
            r_sw_s  <= r_sw_m;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_deb
            logic [DEB_W-1:0] r_cnt;
            logic             r_deb;
            logic             r_press;

            // Debounce: flip only after DEB_CYCLES consecutive differing
            // cycles; a 0->1 flip is registered as a one-cycle press event
            always_ff @(posedge clk) begin
                if (clr_common) begin
                    r_cnt   <= '0;
                    r_deb   <= 1'b0;
                    r_press <= 1'b0;
                end else begin
                    r_press <= 1'b0;
                    if (r_btn_s[gi] == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DEB_LAST) begin
                        r_deb   <= r_btn_s[gi];
                        r_cnt   <= '0;
                        r_press <= r_btn_s[gi];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    // Entry-order FSM: accept only the expected button, flag anything else
    always_comb begin
        w_state_nxt = r_state;
        w_ld_nxt    = '0;
        w_data_nxt  = r_data;
        w_err_nxt   = r_err;
        w_exp_mask  = 3'b001;
        case (r_state)
            S_WAIT_B:  w_exp_mask = 3'b010;
            S_WAIT_OP: w_exp_mask = 3'b100;
            default:   w_exp_mask = 3'b001;
        endcase
        if ((w_press & w_exp_mask) != 3'b000) begin
            w_ld_nxt   = w_exp_mask;
            w_data_nxt = r_sw_s;
            // Another simultaneous event keeps the error flag set
            w_err_nxt  = ((w_press & ~w_exp_mask) != 3'b000);
            case (r_state)
                S_WAIT_A:  w_state_nxt = S_WAIT_B;
                S_WAIT_B:  w_state_nxt = S_WAIT_OP;
                S_WAIT_OP: w_state_nxt = S_DONE;
                default:   w_state_nxt = S_WAIT_B;
            endcase
        end else if (w_press != 3'b000) begin
            w_err_nxt = 1'b1;
        end
    end

    // State and registered status/strobe outputs
    always_ff @(posedge clk) begin
        if (clr_common) begin
            r_state <= S_WAIT_A;
            r_ld    <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ld    <= w_ld_nxt;
            r_data  <= w_data_nxt;
            r_err   <= w_err_nxt;
            r_ready <= (w_state_nxt == S_DONE);
        end
    end

    assign data  = r_data;
    assign ld_A  = r_ld[0];
    assign ld_B  = r_ld[1];
    assign ld_op = r_ld[2];
    assign stage = r_state;
    assign ready = r_ready;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_loader
//  Description : Self-checking bench for operand_loader (DEB_CYCLES = 4).
//                Directed scenarios plus randomized button/switch activity,
//                compared every cycle against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_operand_loader;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       clr_common;
    logic [3:0] sw;
    logic       btn_A;
    logic       btn_B;
    logic       btn_op;
    logic [3:0] data;
    logic       ld_A;
    logic       ld_B;
    logic       ld_op;
    logic [1:0] stage;
    logic       ready;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_ld[3];

    // Behavioural model state
    int         m_stage;
    logic [3:0] m_data;
    logic [2:0] m_ld;
    logic       m_err;
    logic [2:0] m_s1, m_s2, m_deb, m_pend, m_newpend, m_raw;
    logic [3:0] m_sw1, m_sw2;
    int         m_run[3];
    int         m_e;

    operand_loader #(.DEB_CYCLES(DEB), .DEB_W(3)) dut (
        .clk        (clk),
        .clr_common (clr_common),
        .sw         (sw),
        .btn_A      (btn_A),
        .btn_B      (btn_B),
        .btn_op     (btn_op),
        .data       (data),
        .ld_A       (ld_A),
        .ld_B       (ld_B),
        .ld_op      (ld_op),
        .stage      (stage),
        .ready      (ready),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge using the inputs present at that edge
    task model_step();
        m_raw = {btn_op, btn_B, btn_A};
        if (clr_common) begin
            m_stage = 0; m_data = 4'h0; m_ld = 3'b000; m_err = 1'b0;
            m_s1 = 3'b000; m_s2 = 3'b000; m_deb = 3'b000; m_pend = 3'b000;
            m_sw1 = 4'h0; m_sw2 = 4'h0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
        end else begin
            m_ld = 3'b000;
            if (m_pend != 3'b000) begin
                m_e = (m_stage == 1) ? 1 : (m_stage == 2) ? 2 : 0;
                if (m_pend[m_e]) begin
                    m_ld[m_e] = 1'b1;
                    m_data    = m_sw2;
                    m_stage   = (m_stage == 3) ? 1 : m_stage + 1;
                    m_err     = ((m_pend & ~(3'b001 << m_e)) != 3'b000);
                end else begin
                    m_err = 1'b1;
                end
            end
            m_newpend = 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (m_s2[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_deb[i]     = m_s2[i];
                        m_run[i]     = 0;
                        m_newpend[i] = m_s2[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_pend = m_newpend;
            m_s2   = m_s1;
            m_s1   = m_raw;
            m_sw2  = m_sw1;
            m_sw1  = sw;
        end
    endtask

    task compare();
        n_tests++;
        if ({data, ld_op, ld_B, ld_A, stage, ready, err} !==
            {m_data, m_ld, 2'(m_stage), (m_stage == 3), m_err}) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t: got data=%h ld=%b stage=%0d ready=%b err=%b expected data=%h ld=%b stage=%0d ready=%b err=%b",
                     $time, data, {ld_op, ld_B, ld_A}, stage, ready, err,
                     m_data, m_ld, m_stage, (m_stage == 3), m_err);
        end
    endtask

    task check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: model update, per-cycle compare, strobe counting
    task tick();
        @(posedge clk);
        #1;
        model_step();
        compare();
        cnt_ld[0] += int'(ld_A);
        cnt_ld[1] += int'(ld_B);
        cnt_ld[2] += int'(ld_op);
        #1;
    endtask

    task do_reset();
        clr_common = 1'b1;
        btn_A = 1'b0; btn_B = 1'b0; btn_op = 1'b0;
        repeat (2) tick();
        clr_common = 1'b0;
        for (int i = 0; i < 3; i++) cnt_ld[i] = 0;
    endtask

    task press(input int b, input logic [3:0] v);
        sw = v;
        if (b == 0) btn_A = 1'b1; else if (b == 1) btn_B = 1'b1; else btn_op = 1'b1;
        repeat (8) tick();
        btn_A = 1'b0; btn_B = 1'b0; btn_op = 1'b0;
        repeat (8) tick();
    endtask

    int lat;
    int base;

    initial begin
        clr_common = 1'b1; sw = 4'h0; btn_A = 1'b0; btn_B = 1'b0; btn_op = 1'b0;
        for (int i = 0; i < 3; i++) cnt_ld[i] = 0;
        repeat (3) tick();
        check("rst_data",  data, 0);
        check("rst_ld",    {ld_op, ld_B, ld_A}, 0);
        check("rst_stage", stage, 0);
        check("rst_ready", ready, 0);
        check("rst_err",   err, 0);

        // Held A press: one strobe, 7 cycles after the rise
        clr_common = 1'b0;
        for (int i = 0; i < 3; i++) cnt_ld[i] = 0;
        sw = 4'h5; btn_A = 1'b1;
        lat = 0;
        while (lat < 30) begin
            tick();
            lat++;
            if (ld_A) break;
        end
        check("A_latency", lat, 7);
        check("A_data", data, 5);
        check("A_stage", stage, 1);
        base = cnt_ld[0];
        repeat (13) tick();
        check("A_held_restrobe", cnt_ld[0] - base, 0);
        btn_A = 1'b0;
        repeat (8) tick();

        // Short B glitch is filtered
        btn_B = 1'b1;
        repeat (3) tick();
        btn_B = 1'b0;
        repeat (10) tick();
        check("glitch_ldB", cnt_ld[1], 0);
        check("glitch_stage", stage, 1);
        check("glitch_err", err, 0);

        // Full in-order sequence
        do_reset();
        press(0, 4'h3);
        check("seq_A_data", data, 3);
        check("seq_A_stage", stage, 1);
        press(1, 4'hC);
        check("seq_B_data", data, 12);
        check("seq_B_stage", stage, 2);
        press(2, 4'h2);
        check("seq_op_data", data, 2);
        check("seq_op_stage", stage, 3);
        check("seq_ready", ready, 1);
        check("seq_strobes", cnt_ld[0] * 100 + cnt_ld[1] * 10 + cnt_ld[2], 111);

        // Out-of-order opcode press in WAIT_A
        do_reset();
        press(2, 4'h7);
        check("ooo_err", err, 1);
        check("ooo_data", data, 0);
        check("ooo_stage", stage, 0);
        check("ooo_ldop", cnt_ld[2], 0);
        press(0, 4'h6);
        check("ooo_A_err", err, 0);
        check("ooo_A_stage", stage, 1);
        check("ooo_A_data", data, 6);

        // Simultaneous B and opcode in WAIT_B
        sw = 4'hA; btn_B = 1'b1; btn_op = 1'b1;
        repeat (8) tick();
        btn_B = 1'b0; btn_op = 1'b0;
        repeat (8) tick();
        check("sim_ldB", cnt_ld[1], 1);
        check("sim_ldop", cnt_ld[2], 0);
        check("sim_stage", stage, 2);
        check("sim_err", err, 1);
        check("sim_data", data, 10);
        press(2, 4'h1);
        check("sim_op_stage", stage, 3);
        check("sim_op_err", err, 0);

        // New computation from DONE, then reset mid-debounce of B
        press(0, 4'h9);
        check("done_A_data", data, 9);
        check("done_A_stage", stage, 1);
        check("done_A_ready", ready, 0);
        btn_B = 1'b1;
        repeat (4) tick();
        clr_common = 1'b1; btn_B = 1'b0;
        tick();
        check("midrst_data", data, 0);
        check("midrst_stage", stage, 0);
        check("midrst_flags", {ld_op, ld_B, ld_A, ready, err}, 0);
        clr_common = 1'b0;
        base = cnt_ld[1];
        repeat (12) tick();
        check("midrst_no_ldB", cnt_ld[1] - base, 0);

        // Randomized activity checked against the model every cycle
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) btn_A  = ~btn_A;
            if ($urandom_range(0, 7) == 0) btn_B  = ~btn_B;
            if ($urandom_range(0, 7) == 0) btn_op = ~btn_op;
            if ($urandom_range(0, 15) == 0) sw = 4'($urandom);
            clr_common = ($urandom_range(0, 599) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
